// File: rtl/str_up_sample_top.sv
// Top-level wrapper around str_up_sample with an identical port list.
module str_up_sample_top #(
    parameter int DW         = 24,
    parameter int R          = 4,
    parameter int LAST       = 16000,
    parameter int ZERO_STUFF = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] s_axis_tdata,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic          s_axis_tlast,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic          m_axis_tlast,
    output logic          frame_err
);
    str_up_sample #(DW, R, LAST, ZERO_STUFF) u_core (
        clk, rst_n, s_axis_tdata, s_axis_tvalid, s_axis_tready, s_axis_tlast,
        m_axis_tdata, m_axis_tvalid, m_axis_tready, m_axis_tlast, frame_err
    );
endmodule

// File: rtl/str_up_sample.sv
// Streaming up-sampler: repeats (or zero-stuffs) each input sample R times and
// tracks input/output frame position, flagging input framing errors.
module str_up_sample #(
    parameter int DW         = 24,
    parameter int R          = 4,
    parameter int LAST       = 16000,
    parameter int ZERO_STUFF = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] s_axis_tdata,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic          s_axis_tlast,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic          m_axis_tlast,
    output logic          frame_err
);
    localparam int NIN = LAST / R;
    localparam int RW  = $clog2(R);
    localparam int OW  = $clog2(LAST);
    localparam int IW  = (NIN > 1) ? $clog2(NIN) : 1;

    localparam logic [RW-1:0] REP_MAX  = RW'(R - 1);
    localparam logic [OW-1:0] OCNT_MAX = OW'(LAST - 1);
    localparam logic [IW-1:0] ICNT_MAX = IW'(NIN - 1);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_EMIT  = 1'b1;

    logic          state, state_nxt;
    logic [RW-1:0] rep;
    logic [OW-1:0] ocnt;
    logic [IW-1:0] icnt;
    logic [DW-1:0] hold;
    logic          in_xfer, out_xfer, rep_last;

    assign rep_last = (rep == REP_MAX);
    assign in_xfer  = s_axis_tvalid && s_axis_tready;
    assign out_xfer = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (in_xfer) state_nxt = ST_EMIT;
            ST_EMIT:  if (out_xfer && rep_last && !in_xfer) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // Ready reaches back through m_axis_tready only on the final repeat so a
    // new sample can replace the held one without a bubble.
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = hold;
        m_axis_tlast  = 1'b0;
        case (state)
            ST_EMPTY: s_axis_tready = 1'b1;
            ST_EMIT: begin
                s_axis_tready = rep_last && m_axis_tready;
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (ocnt == OCNT_MAX);
                if (ZERO_STUFF != 0 && rep != '0) m_axis_tdata = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep       <= '0;
            ocnt      <= '0;
            icnt      <= '0;
            hold      <= '0;
            frame_err <= 1'b0;
        end else begin
            if (in_xfer) begin
                hold <= s_axis_tdata;
                rep  <= '0;
            end else if (out_xfer && !rep_last) begin
                rep <= rep + RW'(1);
            end

            if (out_xfer) ocnt <= (ocnt == OCNT_MAX) ? '0 : ocnt + OW'(1);

            // Counters free-run through errors; the flag is sticky until reset.
            if (in_xfer) begin
                icnt <= (icnt == ICNT_MAX) ? '0 : icnt + IW'(1);
                if (s_axis_tlast != (icnt == ICNT_MAX)) frame_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_str_up_sample.sv
// Directed bench: sample-hold and zero-stuff instances driven side by side (R=4, LAST=16).
module tb_str_up_sample;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          m_ready = 1'b0;
    logic          sr_sh, sr_zs, mv_sh, mv_zs, ml_sh, ml_zs, fe_sh, fe_zs;
    logic [DW-1:0] md_sh, md_zs;

    int vectors = 0;
    int fails = 0;
    int out_total = 0;
    int in_total = 0;
    logic errexp = 1'b0;

    always #5 clk = ~clk;

    str_up_sample #(.DW(DW), .R(4), .LAST(16), .ZERO_STUFF(0)) u_sh (
        .clk(clk), .rst_n(rst_n), .s_axis_tdata(s_data), .s_axis_tvalid(s_valid),
        .s_axis_tready(sr_sh), .s_axis_tlast(s_last), .m_axis_tdata(md_sh),
        .m_axis_tvalid(mv_sh), .m_axis_tready(m_ready), .m_axis_tlast(ml_sh),
        .frame_err(fe_sh));

    str_up_sample_top #(.DW(DW), .R(4), .LAST(16), .ZERO_STUFF(1)) u_zs (
        .clk(clk), .rst_n(rst_n), .s_axis_tdata(s_data), .s_axis_tvalid(s_valid),
        .s_axis_tready(sr_zs), .s_axis_tlast(s_last), .m_axis_tdata(md_zs),
        .m_axis_tvalid(mv_zs), .m_axis_tready(m_ready), .m_axis_tlast(ml_zs),
        .frame_err(fe_zs));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] val(input int tag, input int i);
        if (tag == 0) return DW'(i + 1);
        return 24'hC00000 | DW'(tag * 256 + i + 1);
    endfunction

    // Streams n samples; bad>=0 puts s_last on that sample only, else on every 4th.
    task automatic stream(input int tag, input int n, input int bad, input bit rnd);
        int si = 0, oi = 0;
        bit ai = 0, ao = 0, stall = 0, done = 0, held, exp_sr;
        logic [DW-1:0] pd_sh = '0, pd_zs = '0, ev;
        logic pl = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk); #1;
            if (ai) begin
                if (s_last != (in_total % 4 == 3)) errexp = 1'b1;
                si++; in_total++;
            end
            if (ao) begin oi++; out_total++; end
            chk("frame_err_sh", 32'(fe_sh), 32'(errexp));
            chk("frame_err_zs", 32'(fe_zs), 32'(errexp));
            if (si == n && oi == 4 * n) begin done = 1; break; end
            m_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_valid = (si < n);
            s_data  = val(tag, si);
            s_last  = (bad >= 0) ? (si == bad) : (si % 4 == 3);
            #1;
            held   = (oi < 4 * si);
            exp_sr = !held || (oi % 4 == 3 && m_ready);
            chk("m_valid_sh", 32'(mv_sh), 32'(held));
            chk("m_valid_zs", 32'(mv_zs), 32'(held));
            chk("s_ready_sh", 32'(sr_sh), 32'(exp_sr));
            chk("s_ready_zs", 32'(sr_zs), 32'(exp_sr));
            if (stall) begin
                chk("stall_data_sh", 32'(md_sh), 32'(pd_sh));
                chk("stall_data_zs", 32'(md_zs), 32'(pd_zs));
                chk("stall_last", 32'(ml_sh), 32'(pl));
            end
            if (held) begin
                ev = val(tag, oi / 4);
                chk("data_sh", 32'(md_sh), 32'(ev));
                chk("data_zs", 32'(md_zs), (oi % 4 == 0) ? 32'(ev) : 32'h0);
                chk("last_sh", 32'(ml_sh), 32'(out_total % 16 == 15));
                chk("last_zs", 32'(ml_zs), 32'(out_total % 16 == 15));
            end
            ao = held && m_ready;
            ai = s_valid && exp_sr;
            stall = held && !m_ready;
            pd_sh = md_sh; pd_zs = md_zs; pl = ml_sh;
        end
        chk("stream_done", 32'(done), 32'h1);
        chk("idle_after", 32'(mv_sh), 32'h0);
        s_valid = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_valid", 32'(mv_sh), 32'h0);
        chk("rst_ready", 32'(sr_sh), 32'h1);
        chk("rst_last", 32'(ml_sh), 32'h0);
        chk("rst_data", 32'(md_sh), 32'h0);
        chk("rst_ferr", 32'(fe_sh), 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        stream(0, 4, -1, 1'b0);   // 1,2,3,4 back-to-back
        stream(1, 8, -1, 1'b1);   // random back-pressure, two frames
        stream(2, 4, 2, 1'b0);    // tlast on sample 3 raises frame_err
        chk("ferr_sticky", 32'(fe_sh), 32'h1);

        // Reset while holding a sample at rep=2.
        @(negedge clk);
        s_valid = 1'b1; s_data = 24'h800001; s_last = 1'b0; m_ready = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("pre_rst_valid", 32'(mv_sh), 32'h1);
        chk("pre_rst_zero", 32'(md_zs), 32'h0);
        chk("pre_rst_hold", 32'(md_sh), 32'h800001);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(mv_sh), 32'h0);
        chk("mid_rst_ready", 32'(sr_sh), 32'h1);
        chk("mid_rst_data", 32'(md_sh), 32'h0);
        chk("mid_rst_last", 32'(ml_sh), 32'h0);
        chk("mid_rst_ferr", 32'(fe_sh), 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        out_total = 0; in_total = 0; errexp = 1'b0;
        stream(3, 4, -1, 1'b0);   // new frame after reset, tlast on output 16

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
